// File: rtl/spikehard_pkg.sv
// Shared types and helpers for the spikehard output stage.
package spikehard_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_CTRL,
      ST_DATA,
      ST_DONE
   } state_t;

   // Integer ceiling division, used to size the per-tick DMA burst.
   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

   // DMA size encoding: 3'b010 for 32-bit words, 3'b011 for 64-bit words.
   function automatic logic [2:0] dma_size_code(input int unsigned bus_width);
      return (bus_width == 32) ? 3'b010 : 3'b011;
   endfunction

endpackage

// File: rtl/spike_bitmap.sv
// Per-tick spike bitmap: indexed bit set, synchronous clear, word-wide read.
module spike_bitmap
   import spikehard_pkg::*;
#(
   parameter  int unsigned NUM_OUTPUTS   = 256,
   parameter  int unsigned DMA_BUS_WIDTH = 64,
   localparam int unsigned IDX_W         = $clog2(NUM_OUTPUTS),
   localparam int unsigned WORDS         = ceil_div(NUM_OUTPUTS, DMA_BUS_WIDTH),
   localparam int unsigned SEL_W         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     set_en,
   input  logic [IDX_W-1:0]         set_index,
   input  logic                     clr,
   input  logic [SEL_W-1:0]         word_sel,
   output logic [DMA_BUS_WIDTH-1:0] word_c
);

   localparam int unsigned PAD_W = WORDS * DMA_BUS_WIDTH;

   logic [NUM_OUTPUTS-1:0] bits;
   logic [PAD_W-1:0]       padded;

   // Bit storage; indices with no matching bit (>= NUM_OUTPUTS) set nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bits <= '0;
      end else if (clr) begin
         bits <= '0;
      end else if (set_en) begin
         for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
            if (set_index == IDX_W'(i)) bits[i] <= 1'b1;
         end
      end
   end

   // Zero-extend to a whole number of bus words so padding reads as 0.
   assign padded = PAD_W'(bits);

   // Word-select read mux.
   always_comb begin
      word_c = '0;
      for (int w = 0; w < int'(WORDS); w++) begin
         if (word_sel == SEL_W'(w)) word_c = padded[w*DMA_BUS_WIDTH +: DMA_BUS_WIDTH];
      end
   end

endmodule

// File: rtl/spike_dma_writer.sv
// Output stage: gathers spikes per tick and writes each tick's bitmap over DMA.
module spike_dma_writer
   import spikehard_pkg::*;
#(
   parameter  int unsigned NUM_OUTPUTS   = 256,
   parameter  int unsigned DMA_BUS_WIDTH = 64,
   localparam int unsigned IDX_W         = $clog2(NUM_OUTPUTS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [31:0]              cfg_num_ticks,
   input  logic [31:0]              cfg_base_index,
   input  logic                     spike_valid,
   output logic                     spike_ready,
   input  logic [IDX_W-1:0]         spike_index,
   input  logic                     tick_end_valid,
   output logic                     tick_end_ready,
   output logic                     dma_write_ctrl_valid,
   input  logic                     dma_write_ctrl_ready,
   output logic [31:0]              dma_write_ctrl_data_index,
   output logic [31:0]              dma_write_ctrl_data_length,
   output logic [2:0]               dma_write_ctrl_data_size,
   output logic                     dma_write_chnl_valid,
   input  logic                     dma_write_chnl_ready,
   output logic [DMA_BUS_WIDTH-1:0] dma_write_chnl_data,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned     WORDS     = ceil_div(NUM_OUTPUTS, DMA_BUS_WIDTH);
   localparam int unsigned     SEL_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [SEL_W-1:0] LAST_WORD = SEL_W'(WORDS - 1);

   state_t                     state, state_nx;
   logic [31:0]                num_ticks, base_index;
   logic [31:0]                tick_cnt, tick_cnt_nx;
   logic [SEL_W-1:0]           word_cnt, word_cnt_nx;
   logic                       bm_set, bm_clr, load_cfg, load_ctrl;
   logic                       spike_hs, tick_hs, ctrl_hs, chnl_hs;
   logic [DMA_BUS_WIDTH-1:0]   bm_word_c;

   assign spike_hs = spike_valid & spike_ready;
   assign tick_hs  = tick_end_valid & tick_end_ready;
   assign ctrl_hs  = dma_write_ctrl_valid & dma_write_ctrl_ready;
   assign chnl_hs  = dma_write_chnl_valid & dma_write_chnl_ready;

   assign dma_write_ctrl_data_length = 32'(WORDS);
   assign dma_write_ctrl_data_size   = dma_size_code(DMA_BUS_WIDTH);

   spike_bitmap #(
      .NUM_OUTPUTS   (NUM_OUTPUTS),
      .DMA_BUS_WIDTH (DMA_BUS_WIDTH)
   ) u_bitmap (
      .clk       (clk),
      .rst       (rst),
      .set_en    (bm_set),
      .set_index (spike_index),
      .clr       (bm_clr),
      .word_sel  (word_cnt_nx),
      .word_c    (bm_word_c)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_nx    = state;
      tick_cnt_nx = tick_cnt;
      word_cnt_nx = word_cnt;
      bm_set      = 1'b0;
      bm_clr      = 1'b0;
      load_cfg    = 1'b0;
      load_ctrl   = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load_cfg    = 1'b1;
               bm_clr      = 1'b1;
               tick_cnt_nx = '0;
               word_cnt_nx = '0;
               state_nx    = (cfg_num_ticks != 32'd0) ? ST_COLLECT : ST_DONE;
            end
         end
         ST_COLLECT: begin
            // A spike arriving with tick_end still lands in the ending tick.
            bm_set = spike_hs;
            if (tick_hs) begin
               load_ctrl = 1'b1;
               state_nx  = ST_CTRL;
            end
         end
         ST_CTRL: begin
            if (ctrl_hs) begin
               word_cnt_nx = '0;
               state_nx    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (chnl_hs) begin
               if (word_cnt == LAST_WORD) begin
                  bm_clr      = 1'b1;
                  word_cnt_nx = '0;
                  tick_cnt_nx = tick_cnt + 32'd1;
                  state_nx    = (tick_cnt + 32'd1 == num_ticks) ? ST_DONE : ST_COLLECT;
               end else begin
                  word_cnt_nx = word_cnt + SEL_W'(1);
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Registered outputs, counters and captured configuration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spike_ready               <= 1'b0;
         tick_end_ready            <= 1'b0;
         dma_write_ctrl_valid      <= 1'b0;
         dma_write_chnl_valid      <= 1'b0;
         busy                      <= 1'b0;
         done                      <= 1'b0;
         dma_write_ctrl_data_index <= '0;
         dma_write_chnl_data       <= '0;
         num_ticks                 <= '0;
         base_index                <= '0;
         tick_cnt                  <= '0;
         word_cnt                  <= '0;
      end else begin
         spike_ready          <= (state_nx == ST_COLLECT);
         tick_end_ready       <= (state_nx == ST_COLLECT);
         dma_write_ctrl_valid <= (state_nx == ST_CTRL);
         dma_write_chnl_valid <= (state_nx == ST_DATA);
         busy                 <= (state_nx == ST_COLLECT) || (state_nx == ST_CTRL) ||
                                 (state_nx == ST_DATA);
         done                 <= (state_nx == ST_DONE);
         tick_cnt             <= tick_cnt_nx;
         word_cnt             <= word_cnt_nx;
         if (load_cfg) begin
            num_ticks  <= cfg_num_ticks;
            base_index <= cfg_base_index;
         end
         if (load_ctrl) dma_write_ctrl_data_index <= base_index + tick_cnt * 32'(WORDS);
         // Read port follows word_cnt_nx, so the word holds while stalled.
         if (state_nx == ST_DATA) dma_write_chnl_data <= bm_word_c;
      end
   end

endmodule

// File: tb/tb_spike_dma_writer.sv
// Directed bench for spike_dma_writer with NUM_OUTPUTS=100, DMA_BUS_WIDTH=64.
module tb_spike_dma_writer;

   localparam int unsigned NO = 100;
   localparam int unsigned BW = 64;
   localparam int unsigned IW = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   cfg_num_ticks = '0;
   logic [31:0]   cfg_base_index = '0;
   logic          spike_valid = 1'b0;
   logic          spike_ready;
   logic [IW-1:0] spike_index = '0;
   logic          tick_end_valid = 1'b0;
   logic          tick_end_ready;
   logic          ctrl_valid;
   logic          ctrl_ready = 1'b0;
   logic [31:0]   ctrl_index, ctrl_length;
   logic [2:0]    ctrl_size;
   logic          chnl_valid;
   logic          chnl_ready = 1'b0;
   logic [BW-1:0] chnl_data;
   logic          busy, done;

   int n_checks = 0;
   int n_err    = 0;

   spike_dma_writer #(.NUM_OUTPUTS(NO), .DMA_BUS_WIDTH(BW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_num_ticks(cfg_num_ticks), .cfg_base_index(cfg_base_index),
      .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_index(spike_index),
      .tick_end_valid(tick_end_valid), .tick_end_ready(tick_end_ready),
      .dma_write_ctrl_valid(ctrl_valid), .dma_write_ctrl_ready(ctrl_ready),
      .dma_write_ctrl_data_index(ctrl_index), .dma_write_ctrl_data_length(ctrl_length),
      .dma_write_ctrl_data_size(ctrl_size),
      .dma_write_chnl_valid(chnl_valid), .dma_write_chnl_ready(chnl_ready),
      .dma_write_chnl_data(chnl_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [31:0]     base;
      logic [2:0]      n;
      logic [3:0][7:0] idx;
      logic [63:0]     w0;
      logic [63:0]     w1;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk); #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_spike_ready"}, 64'(spike_ready), 64'd0);
      check({tag, "_tick_end_ready"}, 64'(tick_end_ready), 64'd0);
      check({tag, "_ctrl_valid"}, 64'(ctrl_valid), 64'd0);
      check({tag, "_chnl_valid"}, 64'(chnl_valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_ctrl_index"}, 64'(ctrl_index), 64'd0);
      check({tag, "_chnl_data"}, chnl_data, 64'd0);
      check({tag, "_ctrl_length"}, 64'(ctrl_length), 64'd2);
      check({tag, "_ctrl_size"}, 64'(ctrl_size), 64'd3);
   endtask

   task automatic do_start(input logic [31:0] base, input logic [31:0] ticks);
      cfg_base_index = base;
      cfg_num_ticks  = ticks;
      start = 1'b1;
      tick_clk();
      start = 1'b0;
   endtask

   task automatic wait_spike_ready(input string name);
      int t = 0;
      while (!spike_ready && t < 50) begin tick_clk(); t++; end
      if (!spike_ready) check({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic send_spike(input logic [7:0] idx);
      spike_valid = 1'b1;
      spike_index = IW'(idx);
      wait_spike_ready("spike");
      tick_clk();
      spike_valid = 1'b0;
   endtask

   task automatic send_tick_end();
      int t = 0;
      tick_end_valid = 1'b1;
      while (!tick_end_ready && t < 50) begin tick_clk(); t++; end
      if (!tick_end_ready) check("tick_end_timeout", 64'd0, 64'd1);
      tick_clk();
      tick_end_valid = 1'b0;
      check("ctrl_valid_after_tick_end", 64'(ctrl_valid), 64'd1);
   endtask

   task automatic read_tick(input logic [31:0] exp_index, input logic [63:0] w0, input logic [63:0] w1);
      int t = 0;
      logic [63:0] exp_w [2];
      exp_w[0] = w0;
      exp_w[1] = w1;
      while (!ctrl_valid && t < 50) begin tick_clk(); t++; end
      check("ctrl_valid", 64'(ctrl_valid), 64'd1);
      check("ctrl_index", 64'(ctrl_index), 64'(exp_index));
      check("ctrl_length", 64'(ctrl_length), 64'd2);
      check("ctrl_size", 64'(ctrl_size), 64'd3);
      ctrl_ready = 1'b1;
      tick_clk();
      ctrl_ready = 1'b0;
      chnl_ready = 1'b1;
      for (int w = 0; w < 2; w++) begin
         check($sformatf("chnl_valid_w%0d", w), 64'(chnl_valid), 64'd1);
         check($sformatf("chnl_data_w%0d", w), chnl_data, exp_w[w]);
         check($sformatf("spike_ready_stall_w%0d", w), 64'(spike_ready), 64'd0);
         tick_clk();
      end
      chnl_ready = 1'b0;
      check("chnl_valid_after_last", 64'(chnl_valid), 64'd0);
   endtask

   initial begin
      vecs[0] = '{base: 32'h40, n: 3'd4, idx: {8'd99, 8'd64, 8'd63, 8'd0},
                  w0: 64'h8000_0000_0000_0001, w1: 64'h0000_0008_0000_0001};
      vecs[1] = '{base: 32'h0, n: 3'd1, idx: {8'd0, 8'd0, 8'd0, 8'd120},
                  w0: 64'h0, w1: 64'h0};
      vecs[2] = '{base: 32'hFFFF_FFFF, n: 3'd3, idx: {8'd0, 8'd70, 8'd5, 8'd5},
                  w0: 64'h20, w1: 64'h40};
      vecs[3] = '{base: 32'h100, n: 3'd3, idx: {8'd0, 8'd98, 8'd127, 8'd1},
                  w0: 64'h2, w1: 64'h0000_0004_0000_0000};

      // Reset state
      repeat (3) tick_clk();
      check_reset_values("reset");
      rst = 1'b0;
      tick_clk();

      // ticks=0 goes straight to DONE with no DMA activity
      do_start(32'h0, 32'd0);
      check("zero_ticks_done", 64'(done), 64'd1);
      check("zero_ticks_busy", 64'(busy), 64'd0);
      for (int c = 0; c < 3; c++) begin
         check("zero_ticks_no_ctrl", 64'(ctrl_valid), 64'd0);
         check("zero_ticks_no_chnl", 64'(chnl_valid), 64'd0);
         tick_clk();
      end

      // Single-tick vectors
      for (int v = 0; v < 4; v++) begin
         do_start(vecs[v].base, 32'd1);
         check($sformatf("v%0d_spike_ready_after_start", v), 64'(spike_ready), 64'd1);
         check($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
         for (int s = 0; s < int'(vecs[v].n); s++) send_spike(vecs[v].idx[s]);
         send_tick_end();
         read_tick(vecs[v].base, vecs[v].w0, vecs[v].w1);
         check($sformatf("v%0d_done", v), 64'(done), 64'd1);
         check($sformatf("v%0d_busy_end", v), 64'(busy), 64'd0);
      end

      // Backpressure on ctrl and chnl
      do_start(32'h40, 32'd1);
      send_spike(8'd0); send_spike(8'd63); send_spike(8'd64); send_spike(8'd99);
      send_tick_end();
      for (int c = 0; c < 2; c++) begin
         check("bp_ctrl_hold_valid", 64'(ctrl_valid), 64'd1);
         check("bp_ctrl_hold_index", 64'(ctrl_index), 64'h40);
         tick_clk();
      end
      ctrl_ready = 1'b1;
      tick_clk();
      ctrl_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check("bp_w0_valid", 64'(chnl_valid), 64'd1);
         check("bp_w0_hold", chnl_data, 64'h8000_0000_0000_0001);
         check("bp_spike_ready", 64'(spike_ready), 64'd0);
         tick_clk();
      end
      chnl_ready = 1'b1;
      tick_clk();
      chnl_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         check("bp_w1_hold", chnl_data, 64'h0000_0008_0000_0001);
         check("bp_spike_ready_w1", 64'(spike_ready), 64'd0);
         tick_clk();
      end
      chnl_ready = 1'b1;
      tick_clk();
      chnl_ready = 1'b0;
      check("bp_done", 64'(done), 64'd1);
      check("bp_chnl_idle", 64'(chnl_valid), 64'd0);

      // Multi-tick with an empty middle tick
      do_start(32'h10, 32'd3);
      send_spike(8'd3);
      send_tick_end();
      read_tick(32'h10, 64'h8, 64'h0);
      check("mt_back_to_collect", 64'(spike_ready), 64'd1);
      check("mt_not_done", 64'(done), 64'd0);
      send_tick_end();
      read_tick(32'h12, 64'h0, 64'h0);
      check("mt_back_to_collect2", 64'(spike_ready), 64'd1);
      send_spike(8'd65);
      send_tick_end();
      read_tick(32'h14, 64'h0, 64'h2);
      check("mt_done", 64'(done), 64'd1);

      // Spike and tick_end in the same cycle
      do_start(32'h0, 32'd1);
      spike_valid    = 1'b1;
      spike_index    = IW'(5);
      tick_end_valid = 1'b1;
      wait_spike_ready("same_cycle");
      tick_clk();
      spike_valid    = 1'b0;
      tick_end_valid = 1'b0;
      read_tick(32'h0, 64'h20, 64'h0);
      check("same_cycle_done", 64'(done), 64'd1);

      // Reset after word 0 handshake
      do_start(32'h40, 32'd2);
      send_spike(8'd0); send_spike(8'd99);
      send_tick_end();
      ctrl_ready = 1'b1;
      tick_clk();
      ctrl_ready = 1'b0;
      chnl_ready = 1'b1;
      check("rst_seq_w0", chnl_data, 64'h1);
      tick_clk();
      chnl_ready = 1'b0;
      check("rst_seq_w1", chnl_data, 64'h0000_0008_0000_0000);
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      tick_clk();
      rst = 1'b0;
      tick_clk();
      do_start(32'h0, 32'd1);
      send_spike(8'd1);
      send_tick_end();
      read_tick(32'h0, 64'h2, 64'h0);
      check("post_rst_done", 64'(done), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/spike_dma_writer.md
# spike_dma_writer

Downstream output stage of the spikehard accelerator. Collects output-core spike indices over each tick into a NUM_OUTPUTS-bit bitmap. At each end-of-tick marker it issues one DMA write transaction of ceil(NUM_OUTPUTS/DMA_BUS_WIDTH) words. It drives the `dma_write_ctrl_*` / `dma_write_chnl_*` ports of the top level and signals completion after the configured number of ticks.

## Interface
Parameters:
- NUM_OUTPUTS, 256, number of output neurons (bitmap width)
- DMA_BUS_WIDTH, 64, DMA word width; 32 or 64 only
- WORDS (localparam), ceil(NUM_OUTPUTS/DMA_BUS_WIDTH), words per tick

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  one-cycle run start pulse
- cfg_num_ticks  in  32  ticks to write per run; sampled on start
- cfg_base_index  in  32  DMA word index of tick 0; sampled on start
- spike_valid / spike_ready  in/out  1/1  spike handshake
- spike_index  in  $clog2(NUM_OUTPUTS)  output neuron index
- tick_end_valid / tick_end_ready  in/out  1/1  end-of-tick marker handshake
- dma_write_ctrl_valid / _ready  out/in  1/1  control handshake
- dma_write_ctrl_data_index  out  32  cfg_base_index + tick_cnt*WORDS
- dma_write_ctrl_data_length  out  32  WORDS
- dma_write_ctrl_data_size  out  3  3'b010 (32-bit) / 3'b011 (64-bit)
- dma_write_chnl_valid / _ready  out/in  1/1  data handshake
- dma_write_chnl_data  out  DMA_BUS_WIDTH  bitmap word
- busy  out  1  state != IDLE and != DONE
- done  out  1  high in DONE

## Operation
- States: IDLE, COLLECT, CTRL, DATA, DONE.
- IDLE / DONE:
  - start with cfg_num_ticks != 0 → COLLECT; bitmap cleared, tick_cnt = 0.
  - start with cfg_num_ticks == 0 → DONE.
  - start in any other state is ignored.
- COLLECT:
  - spike_ready = tick_end_ready = 1.
  - A spike handshake ORs bit spike_index into the bitmap. Duplicate indices are idempotent.
  - An index ≥ NUM_OUTPUTS is accepted and dropped.
  - A tick_end handshake → CTRL.
  - Spike and tick_end in the same cycle: the spike belongs to the ending tick.
- CTRL: dma_write_ctrl_valid = 1. On handshake → DATA, word_cnt = 0.
- DATA:
  - dma_write_chnl_valid = 1; data = bitmap[word_cnt*DMA_BUS_WIDTH +: DMA_BUS_WIDTH].
  - Bits ≥ NUM_OUTPUTS read as 0.
  - Each handshake increments word_cnt.
  - On the last word: clear the bitmap and increment tick_cnt. If tick_cnt+1 == num_ticks → DONE, else → COLLECT.
- Outside COLLECT, spike_ready = tick_end_ready = 0 (upstream stalls).
- Control and data outputs stay stable while their valid is high and ready is low.
- tick_cnt and index arithmetic: 32-bit, wrap modulo 2^32, no saturation.

## Timing
- Reset values:
  - all valid/ready outputs, busy and done = 0; ctrl index = 0; chnl data = 0.
  - ctrl length = WORDS and ctrl size = size code (constant).
  - bitmap, tick_cnt and word_cnt = 0; state IDLE.
- Cycle-level latencies:
  - start → COLLECT: spike_ready high next cycle.
  - tick_end handshake → ctrl_valid next cycle.
  - ctrl handshake → chnl_valid next cycle.
  - Data words: one per cycle while ready is held.
  - Last-word handshake → spike_ready (or done) next cycle.
- Minimum flush cost per tick: WORDS+2 cycles during which upstream is stalled.
- rst mid-run returns to reset values immediately. The partial bitmap and any outstanding DMA transaction are abandoned.

## Structure
- Package spikehard_pkg holds:
  - the state enum;
  - the dma_size_code(DMA_BUS_WIDTH) function;
  - the ceil-div helper for WORDS.
- One natural sub-module, spike_bitmap, with:
  - a set port (index, enable);
  - a synchronous clear;
  - a word-select read port.
- The FSM, counters and DMA handshakes stay in spike_dma_writer.

## Test plan
All scenarios use NUM_OUTPUTS=100 and DMA_BUS_WIDTH=64, so WORDS=2 and size code = 3'b011.
- Basic tick:
  - Stimulus: start, base=0x40, ticks=1; spikes 0, 63, 64, 99; tick_end.
  - Required: ctrl index 0x40, length 2; words 0x8000_0000_0000_0001 then 0x0000_0008_0000_0001; done.
- Backpressure:
  - Stimulus: same as basic tick, with chnl_ready low for 5 cycles.
  - Required: data held stable; same two words; spike_ready stays 0 until the last handshake.
- Multi-tick:
  - Stimulus: ticks=3, base=0x10, empty tick in middle.
  - Required: ctrl indices 0x10, 0x12, 0x14; middle tick words both 0; bitmap cleared between ticks.
- Edge cases:
  - Stimulus 1: spike 5 and tick_end in the same cycle. Required: bit 5 set in word 0.
  - Stimulus 2: spike index 120. Required: dropped; padding bits 100..127 zero.
  - Stimulus 3: ticks=0. Required: DONE next cycle, no DMA activity.
- Reset mid-DATA:
  - Stimulus: assert rst after word 0 handshake.
  - Required: all outputs at reset values; a new start then yields a clean tick with the old bitmap gone.
